// File: rtl/if_unit.sv
// Instruction fetch stage: owns the PC, fetches from variable-latency memory, holds ins until ack.
// Optional misaligned-target halt enabled by defining IF_ALIGN_CHECK_EN.
module if_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ins,
    output logic             ins_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             ins_ack,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);

`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StFetch, StWait, StIssue, StHalt} state_e;
`else
    typedef enum logic [1:0] {StFetch, StWait, StIssue} state_e;
`endif

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ins_q, ins_d;
    logic             ins_valid_q, ins_valid_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [31:0]      jump_target, branch_target, next_pc_raw, next_pc;

    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {pc_plus4[31:28], ins_q[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{ins_q[15]}}, ins_q[15:0], 2'b00};

    always_comb begin
        next_pc_raw = pc_plus4;
        if (jump) begin
            next_pc_raw = jump_target;
        end else if (branch && zero) begin
            next_pc_raw = branch_target;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    assign next_pc = next_pc_raw;
    assign halted  = (state_q == StHalt);
`else
    assign next_pc = next_pc_raw & ~32'h3;
    assign halted  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        retired_d   = retired_q;
        case (state_q)
            StFetch: begin
                // Any rvalid seen here belongs to no outstanding request.
                state_d = StWait;
            end
            StWait: begin
                if (imem_rvalid) begin
                    ins_d       = imem_rdata;
                    ins_valid_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (ins_ack) begin
                    pc_d        = next_pc;
                    retired_d   = retired_q + CNT_W'(1);
                    ins_valid_d = 1'b0;
                    state_d     = StFetch;
`ifdef IF_ALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = StHalt;
                    end
`endif
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            ins_q       <= 32'h0;
            ins_valid_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            retired_q   <= retired_d;
        end
    end

    // Gated by rst so the request stays low while reset holds the FSM in fetch.
    assign imem_req  = (state_q == StFetch) && !rst;
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_if_unit.sv
// Directed self-checking bench for if_unit; the bench plays the instruction memory cycle by cycle.
module tb_if_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ins_ack;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [15:0] retired;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    if_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .ins_ack    (ins_ack),
        .branch     (branch),
        .zero       (zero),
        .jump       (jump),
        .retired    (retired),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; memory answers lat cycles after the request cycle.
    task automatic fetch(input logic [31:0] data, input int lat);
        check("req_hi", 32'(imem_req), 32'd1);
        tick();
        for (int i = 1; i < lat; i++) begin
            check("req_single", 32'(imem_req), 32'd0);
            check("vld_wait", 32'(ins_valid), 32'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        #1;
        check("vld_rv_cycle", 32'(ins_valid), 32'd0);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("vld_issue", 32'(ins_valid), 32'd1);
        check("ins_issue", ins, data);
    endtask

    task automatic retire(input logic b, input logic z, input logic j);
        ins_ack = 1'b1;
        branch  = b;
        zero    = z;
        jump    = j;
        tick();
        ins_ack = 1'b0;
        branch  = 1'b0;
        zero    = 1'b0;
        jump    = 1'b0;
        #1;
        check("vld_after_ack", 32'(ins_valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        ins_ack     = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        jump        = 1'b0;
        repeat (2) tick();

        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_ins", ins, 32'h0);
        check("rst_vld", 32'(ins_valid), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        rst = 1'b0;
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_3000);

        // rvalid during FETCH must be ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        check("fetch_rv_ign_vld", 32'(ins_valid), 32'd0);
        check("fetch_rv_ign_ins", ins, 32'h0);
        check("wait_req_lo", 32'(imem_req), 32'd0);
        imem_rdata = 32'h2008_0005;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("t1_vld", 32'(ins_valid), 32'd1);
        check("t1_ins", ins, 32'h2008_0005);
        check("t1_req_lo", 32'(imem_req), 32'd0);
        retire(1'b0, 1'b0, 1'b0);
        check("t1_pc", pc, 32'h0000_3004);
        check("t1_addr", imem_addr, 32'h0000_3004);
        check("t1_req_again", 32'(imem_req), 32'd1);
        check("t1_retired", 32'(retired), 32'd1);

        // latency 4, then stall with ack low for 5 cycles
        fetch(32'h1234_5678, 4);
        for (int i = 0; i < 5; i++) begin
            check("stall_pc", pc, 32'h0000_3004);
            check("stall_ins", ins, 32'h1234_5678);
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_retired", 32'(retired), 32'd1);
            check("stall_vld", 32'(ins_valid), 32'd1);
            tick();
        end
        retire(1'b0, 1'b0, 1'b0);
        check("t2_pc", pc, 32'h0000_3008);
        check("t2_retired", 32'(retired), 32'd2);

        // backward branch taken: 300C - 8
        fetch(32'h1000_FFFE, 1);
        check("br_pc_plus4", pc_plus4, 32'h0000_300C);
        retire(1'b1, 1'b1, 1'b0);
        check("br_taken_pc", pc, 32'h0000_3004);
        fetch(32'h0000_0020, 1);
        retire(1'b0, 1'b0, 1'b0);
        check("seq_pc", pc, 32'h0000_3008);
        fetch(32'h1000_FFFE, 2);
        retire(1'b1, 1'b0, 1'b0);
        check("br_not_taken_pc", pc, 32'h0000_300C);
        fetch(32'h0000_0020, 1);
        retire(1'b0, 1'b0, 1'b0);
        check("seq_pc2", pc, 32'h0000_3010);

        // jump beats branch
        fetch(32'h0800_0C00, 1);
        retire(1'b1, 1'b1, 1'b1);
        check("jump_pc", pc, 32'h0000_3000);
        check("jump_retired", 32'(retired), 32'd7);

        // branch to FFFF_FFFC, then sequential wrap to 0
        fetch(32'h1000_F3FE, 1);
        retire(1'b1, 1'b1, 1'b0);
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        fetch(32'h0000_0020, 1);
        retire(1'b0, 1'b0, 1'b0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_retired", 32'(retired), 32'd9);
        check("halted_lo", 32'(halted), 32'd0);

        // ack outside ISSUE is ignored
        ins_ack = 1'b1;
        jump    = 1'b1;
        branch  = 1'b1;
        zero    = 1'b1;
        tick();
        check("stray_ack_pc", pc, 32'h0);
        check("stray_ack_ret", 32'(retired), 32'd9);
        tick();
        check("stray_ack_pc2", pc, 32'h0);
        check("stray_ack_req", 32'(imem_req), 32'd0);
        ins_ack = 1'b0;
        jump    = 1'b0;
        branch  = 1'b0;
        zero    = 1'b0;

        // asynchronous reset in WAIT
        #2;
        rst = 1'b1;
        #1;
        check("midrst_pc", pc, 32'h0000_3000);
        check("midrst_vld", 32'(ins_valid), 32'd0);
        check("midrst_ins", ins, 32'h0);
        check("midrst_retired", 32'(retired), 32'd0);
        check("midrst_req", 32'(imem_req), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("postrst_req", 32'(imem_req), 32'd1);
        check("postrst_addr", imem_addr, 32'h0000_3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
